// File: rtl/seg_digit_encoder.sv
// Binary (0-99) to two-digit seven-segment encoder using sequential double dabble,
// plus the free-running refresh tick that paces the downstream digit multiplexer.
module seg_digit_encoder #(
    parameter int DIN_W         = 7,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIN_W-1:0] value,
    input  logic             load,
    output logic             busy,
    output logic [6:0]       seg_ones,
    output logic [6:0]       seg_tens,
    output logic             overflow,
    output logic             refresh_tick
);

    localparam int STEP_W = (DIN_W < 2) ? 1 : $clog2(DIN_W);
    localparam int REF_W  = $clog2(REFRESH_DIV);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIN_W - 1);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_ZERO     = 7'b1000000;
    localparam logic [6:0] SEG_DASH     = 7'b0111111;
    localparam logic [6:0] SEG_BLANK    = 7'b1111111;
    localparam logic [6:0] SEG_TENS_RST = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DIN_W-1:0]      r_bin;
    logic [7:0]            r_bcd;
    logic [STEP_W-1:0]     r_step;
    logic                  r_ovf_pend;
    logic [6:0]            r_seg_ones;
    logic [6:0]            r_seg_tens;
    logic                  r_overflow;
    logic [REF_W-1:0]      r_ref_cnt;

    logic [DIN_W+7:0]      w_value_ext;
    logic                  w_over;
    logic [3:0]            w_ones_adj;
    logic [3:0]            w_tens_adj;
    logic [DIN_W+7:0]      w_shifted;
    logic [6:0]            w_ones_seg;
    logic [6:0]            w_tens_seg;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Widened compare so any DIN_W is judged against 99 without truncation.
    assign w_value_ext = {8'd0, value};
    assign w_over      = (w_value_ext > (DIN_W + 8)'(99));

    assign w_ones_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
    assign w_tens_adj = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
    assign w_shifted  = {w_tens_adj, w_ones_adj, r_bin} << 1;

    assign w_ones_seg = seg_code(r_bcd[3:0]);
    assign w_tens_seg = ((BLANK_LEADING != 0) && (r_bcd[7:4] == 4'd0)) ? SEG_BLANK
                                                                        : seg_code(r_bcd[7:4]);

    // load is a request sampled only in IDLE; busy is high in every other state and
    // any load seen while busy is dropped, so the requester must re-assert in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (load) w_state_next = w_over ? ST_UPDATE : ST_SHIFT;
            ST_SHIFT:  if (r_step == LAST_STEP) w_state_next = ST_UPDATE;
            ST_UPDATE: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_step     <= '0;
            r_ovf_pend <= 1'b0;
            r_seg_ones <= SEG_ZERO;
            r_seg_tens <= SEG_TENS_RST;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        r_ovf_pend <= w_over;
                        if (!w_over) begin
                            r_bin  <= value;
                            r_bcd  <= '0;
                            r_step <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= w_shifted;
                    r_step         <= r_step + STEP_W'(1);
                end
                // Display registers move only here, so the multiplexer never sees partial BCD.
                ST_UPDATE: begin
                    if (r_ovf_pend) begin
                        r_seg_ones <= SEG_DASH;
                        r_seg_tens <= SEG_DASH;
                        r_overflow <= 1'b1;
                    end else begin
                        r_seg_ones <= w_ones_seg;
                        r_seg_tens <= w_tens_seg;
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                   r_ref_cnt <= '0;
        else if (r_ref_cnt == REF_LAST) r_ref_cnt <= '0;
        else                          r_ref_cnt <= r_ref_cnt + REF_W'(1);
    end

    assign refresh_tick = (r_ref_cnt == REF_LAST);
    assign busy         = (r_state != ST_IDLE);
    assign seg_ones     = r_seg_ones;
    assign seg_tens     = r_seg_tens;
    assign overflow     = r_overflow;

endmodule
